// File: rtl/sprite_draw_scheduler.sv
// Round-robin scheduler sharing one 5x5 sprite drawer and the VGA write port
// among NUM_REQ requesters, with erase forcing, pixel realignment and a watchdog.
module sprite_draw_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [NUM_REQ-1:0]     req_erase,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   draw_rst_n,
  output logic                   draw_en,
  output logic [7:0]             draw_x0,
  output logic [6:0]             draw_y0,
  input  logic [7:0]             draw_x,
  input  logic [6:0]             draw_y,
  input  logic                   draw_colour,
  input  logic                   draw_done,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_FLUSH,
    S_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    x0_q, x0_d;
  logic [6:0]    y0_q, y0_d;
  logic          erase_q, erase_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    pix_x_q, pix_x_d;
  logic [6:0]    pix_y_q, pix_y_d;
  logic          plot_q, plot_d;
  logic          terr_q, terr_d;

  logic          found;
  logic [IW-1:0] pick;
  int            j;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    erase_d = erase_q;
    wd_d    = wd_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    plot_d  = 1'b0;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = pick;
          x0_d    = req_x[8*pick +: 8];
          y0_d    = req_y[7*pick +: 7];
          erase_d = req_erase[pick];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        wd_d    = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        // Coordinates are delayed one cycle to line up with the ROM colour.
        pix_x_d = draw_x;
        pix_y_d = draw_y;
        plot_d  = 1'b1;
        wd_d    = wd_q + 1'b1;
        if (draw_done) begin
          state_d = S_FLUSH;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_ACK;
      S_ACK: begin
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      erase_q <= 1'b0;
      wd_q    <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      plot_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      erase_q <= erase_d;
      wd_q    <= wd_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      plot_q  <= plot_d;
      terr_q  <= terr_d;
    end
  end

  logic [NUM_REQ-1:0] onehot;

  always_comb begin
    onehot      = NUM_REQ'(1) << idx_q;
    grant       = (state_q != S_IDLE) ? onehot : '0;
    ack         = (state_q == S_ACK) ? onehot : '0;
    draw_en     = (state_q == S_DRAW);
    // Drawer stays out of reset through FLUSH so its ROM output remains valid.
    draw_rst_n  = (state_q == S_DRAW) || (state_q == S_FLUSH);
    draw_x0     = x0_q;
    draw_y0     = y0_q;
    vga_x       = pix_x_q;
    vga_y       = pix_y_q;
    vga_plot    = plot_q;
    vga_colour  = (plot_q && !erase_q) ? {3{draw_colour}} : 3'b000;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: behavioural 5x5 drawer model, pixel and ack
// scoreboards, and directed service sequences.
module tb_sprite_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [3:0]  req_erase;
  logic [3:0]  grant, ack;
  logic        draw_rst_n, draw_en;
  logic [7:0]  draw_x0, draw_x, vga_x;
  logic [6:0]  draw_y0, draw_y, vga_y;
  logic        draw_colour, draw_done;
  logic [2:0]  vga_colour;
  logic        vga_plot, timeout_err;

  int checks = 0;
  int failures = 0;
  int n_plot = 0;

  always #5 clock = ~clock;

  sprite_draw_scheduler #(.NUM_REQ(4), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_erase(req_erase), .grant(grant), .ack(ack), .draw_rst_n(draw_rst_n),
    .draw_en(draw_en), .draw_x0(draw_x0), .draw_y0(draw_y0), .draw_x(draw_x),
    .draw_y(draw_y), .draw_colour(draw_colour), .draw_done(draw_done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .timeout_err(timeout_err)
  );

  // ROM contents of the sprite: pixel index c -> 1-bit colour.
  function automatic logic rom(input int c);
    return c[0] ^ c[2];
  endfunction

  // Drawer model: sync active-low reset, row-major 5x5 walk, registered ROM.
  logic [4:0] c_q;
  logic [7:0] sx_q;
  logic [6:0] sy_q;
  logic       col_q;
  logic       hang = 1'b0;

  always @(posedge clock) begin
    col_q <= rom(int'(c_q));
    if (!draw_rst_n) begin
      c_q  <= 5'd0;
      sx_q <= draw_x0;
      sy_q <= draw_y0;
    end else if (draw_en) begin
      c_q <= (c_q == 5'd24) ? 5'd0 : c_q + 5'd1;
    end
  end

  assign draw_x      = sx_q + 8'(c_q % 5);
  assign draw_y      = sy_q + 7'(c_q / 5);
  assign draw_colour = col_q;
  assign draw_done   = !hang && (c_q == 5'd24);

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [3:0] g;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_ack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_service(input int i, input int x, input int y, input bit erase, input int ndraw);
    pix_t p;
    for (int k = 0; k < ndraw; k++) begin
      p.x = 8'(x + (k % 25) % 5);
      p.y = 7'(y + (k % 25) / 5);
      p.c = erase ? 3'b000 : {3{rom(k % 25)}};
      p.g = 4'(1 << i);
      exp_pix.push_back(p);
    end
    exp_ack.push_back(i);
  endtask

  // Monitor: compare every plot and every ack against the scoreboard queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (vga_plot) begin
        n_plot++;
        checks++;
        if (exp_pix.size() == 0) begin
          failures++;
          $display("FAIL unexpected_plot actual=(%0d,%0d) required=none", vga_x, vga_y);
        end else begin
          pix_t e;
          e = exp_pix.pop_front();
          if ({vga_x, vga_y, vga_colour, grant} !== {e.x, e.y, e.c, e.g}) begin
            failures++;
            $display("FAIL pixel actual=(%0d,%0d) c=%0b g=%b required=(%0d,%0d) c=%0b g=%b",
                     vga_x, vga_y, vga_colour, grant, e.x, e.y, e.c, e.g);
          end
        end
      end
      if (ack != 4'b0000) begin
        checks++;
        if (exp_ack.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ack actual=%b required=none", ack);
        end else begin
          int ei;
          ei = exp_ack.pop_front();
          if (ack !== 4'(1 << ei)) begin
            failures++;
            $display("FAIL ack actual=%b required=%b", ack, 4'(1 << ei));
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int x, input int y, input bit e);
    req_x[8*i +: 8] = 8'(x);
    req_y[7*i +: 7] = 7'(y);
    req_erase[i]    = e;
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (ack === 4'b0000 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (ack === 4'b0000) begin
      checks++;
      failures++;
      $display("FAIL %s_ack_wait actual=none required=ack", name);
    end
  endtask

  // Called at the negedge where req was raised; checks the following LOAD cycle.
  task automatic check_load(input string name, input int i, input int x, input int y);
    @(negedge clock);
    chk({name, "_load_grant"}, 32'(grant), 32'(1 << i));
    chk({name, "_load_rst_n"}, 32'(draw_rst_n), 32'(0));
    chk({name, "_load_en"}, 32'(draw_en), 32'(0));
    chk({name, "_load_x0"}, 32'(draw_x0), 32'(x));
    chk({name, "_load_y0"}, 32'(draw_y0), 32'(y));
  endtask

  task automatic settle(input string name);
    repeat (3) @(negedge clock);
    chk({name, "_pix_left"}, 32'(exp_pix.size()), 32'(0));
    chk({name, "_ack_left"}, 32'(exp_ack.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int base, n;
    reset = 1'b1;
    req = 4'b0000;
    req_x = '0;
    req_y = '0;
    req_erase = 4'b0000;
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_draw_en", 32'(draw_en), 32'(0));
    chk("rst_draw_rst_n", 32'(draw_rst_n), 32'(0));
    chk("rst_draw_xy0", 32'({draw_x0, draw_y0}), 32'(0));
    chk("rst_vga_xy", 32'({vga_x, vga_y}), 32'(0));
    chk("rst_vga_colour", 32'(vga_colour), 32'(0));
    chk("rst_vga_plot", 32'(vga_plot), 32'(0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(0));
    reset = 1'b0;
    @(negedge clock);

    // Round robin from reset: 0,1,2,3,0 with one IDLE cycle between services.
    set_req(0, 10, 20, 0);
    set_req(1, 40, 5, 0);
    set_req(2, 30, 40, 0);
    set_req(3, 100, 60, 0);
    push_service(0, 10, 20, 0, 25);
    push_service(1, 40, 5, 0, 25);
    push_service(2, 30, 40, 0, 25);
    push_service(3, 100, 60, 0, 25);
    push_service(0, 10, 20, 0, 25);
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      wait_ack("rr");
      if (s < 4) begin
        @(negedge clock);
        chk("rr_idle_gap", 32'(grant), 32'(0));
        @(negedge clock);
        chk("rr_next_load", 32'(grant), 32'(1 << ((s + 1) % 4)));
      end else begin
        req = 4'b0000;
      end
    end
    settle("rr");

    // Single request for requester 0 (ptr now 1, wraps to 0).
    push_service(0, 10, 20, 0, 25);
    req = 4'b0001;
    check_load("single", 0, 10, 20);
    wait_ack("single");
    req = 4'b0000;
    settle("single");

    // Erase pass for requester 2.
    set_req(2, 30, 40, 1);
    push_service(2, 30, 40, 1, 25);
    req = 4'b0100;
    check_load("erase", 2, 30, 40);
    wait_ack("erase");
    req = 4'b0000;
    settle("erase");
    chk("pre_timeout_err", 32'(timeout_err), 32'(0));

    // Drawer never finishes: abort after 64 DRAW cycles, still ack.
    hang = 1'b1;
    push_service(1, 40, 5, 0, 64);
    req = 4'b0010;
    check_load("timeout", 1, 40, 5);
    wait_ack("timeout");
    req = 4'b0000;
    hang = 1'b0;
    settle("timeout");
    chk("timeout_err_set", 32'(timeout_err), 32'(1));

    // Next request served normally; error stays sticky.
    push_service(3, 100, 60, 0, 25);
    req = 4'b1000;
    check_load("after_to", 3, 100, 60);
    wait_ack("after_to");
    req = 4'b0000;
    settle("after_to");
    chk("timeout_err_sticky", 32'(timeout_err), 32'(1));

    // req dropped and coordinates changed mid-DRAW: latched values persist.
    set_req(2, 50, 30, 0);
    push_service(2, 50, 30, 0, 25);
    req = 4'b0100;
    check_load("drop", 2, 50, 30);
    repeat (6) @(negedge clock);
    req = 4'b0000;
    set_req(2, 200, 7, 1);
    wait_ack("drop");
    settle("drop");

    // Async reset at pixel 12 of a service for requester 2 (ptr is 3 here).
    set_req(2, 60, 10, 0);
    push_service(2, 60, 10, 0, 25);
    req = 4'b0100;
    check_load("rst_mid", 2, 60, 10);
    base = n_plot;
    n = 0;
    while (n_plot < base + 12 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("rst_mid_reached_px12", 32'(n_plot - base), 32'(12));
    reset = 1'b1;
    #1;
    chk("rst_mid_plot", 32'(vga_plot), 32'(0));
    chk("rst_mid_grant", 32'(grant), 32'(0));
    chk("rst_mid_draw_en", 32'(draw_en), 32'(0));
    chk("rst_mid_ack", 32'(ack), 32'(0));
    req = 4'b0000;
    exp_pix.delete();
    exp_ack.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_terr_clear", 32'(timeout_err), 32'(0));

    // Fresh request after reset: ptr is 0 again, so 0 beats 3.
    set_req(0, 10, 20, 0);
    set_req(3, 100, 60, 0);
    push_service(0, 10, 20, 0, 25);
    req = 4'b1001;
    check_load("post_rst", 0, 10, 20);
    wait_ack("post_rst");
    req = 4'b0000;
    settle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
